// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA/DVI timing generator with a pixel front end. Produces
//   registered sync/enable/colour outputs, a programmable-lead pixel request
//   towards the frame-buffer side, and frame/line start strobes.
//
// Ports
//   vga_clk      in   pixel clock
//   sys_rst      in   synchronous, active-high reset
//   timing_en    in   run request; dropping it finishes the current frame first
//   mode         in   0=pixel_data, 1=colour bars, 2=checkerboard, 3=black
//   pixel_data   in   pixel answering the outstanding request
//   data_req     out  pixel request for (pixel_xpos, pixel_ypos)
//   pixel_xpos   out  requested column (0 when data_req=0)
//   pixel_ypos   out  requested row    (0 when data_req=0)
//   vga_hs       out  horizontal sync
//   vga_vs       out  vertical sync
//   vga_de       out  active-video enable
//   vga_rgb      out  pixel out, 0 outside active video
//   frame_start  out  1-cycle strobe at counter position (0,0)
//   line_start   out  1-cycle strobe at every cnt_h=0
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned REQ_LEAD = 1
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              timing_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              frame_start,
  output logic              line_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;
  localparam int unsigned BAR_W   = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_C   = CNT_W'(HA);
  localparam logic [CNT_W-1:0] HE_C   = CNT_W'(HA + H_DISP);
  localparam logic [CNT_W-1:0] VA_C   = CNT_W'(VA);
  localparam logic [CNT_W-1:0] VE_C   = CNT_W'(VA + V_DISP);
  localparam logic [CNT_W-1:0] RQ_S   = CNT_W'(HA - REQ_LEAD);
  localparam logic [CNT_W-1:0] RQ_E   = CNT_W'(HA + H_DISP - REQ_LEAD);

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_h, cnt_v;
  logic [1:0]        mode_q;
  logic              running;
  logic              frame_end;

  logic              h_act, v_act, de_d, req_d;
  logic [CNT_W-1:0]  act_x, act_y;
  logic [15:0]       pat_colour;
  logic [DATA_W-1:0] rgb_d;
  int unsigned       bar_i;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  assign running   = (state != PARK);
  assign frame_end = (cnt_h == H_LAST) && (cnt_v == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) state <= PARK;
    else         state <= state_nxt;
  end

  // A timing_en return while draining wins over the frame-end park decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      PARK:    if (timing_en) state_nxt = RUN;
      RUN:     if (!timing_en) state_nxt = DRAIN;
      DRAIN: begin
        if (timing_en)      state_nxt = RUN;
        else if (frame_end) state_nxt = PARK;
      end
      default: state_nxt = PARK;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst || !running) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
    end else begin
      cnt_h <= cnt_h + 1'b1;
    end
  end

  // Mode only changes at the frame boundary (or while parked) to avoid tearing.
  always_ff @(posedge vga_clk) begin
    if (sys_rst)                     mode_q <= '0;
    else if (!running || frame_end)  mode_q <= mode;
  end

  always_comb begin
    h_act      = (cnt_h >= HA_C) && (cnt_h < HE_C);
    v_act      = (cnt_v >= VA_C) && (cnt_v < VE_C);
    de_d       = h_act && v_act;
    req_d      = v_act && (cnt_h >= RQ_S) && (cnt_h < RQ_E) && (mode_q == 2'd0);
    act_x      = cnt_h - HA_C;
    act_y      = cnt_v - VA_C;
    bar_i      = 32'(act_x) / BAR_W;
    if (bar_i > 32'd7) bar_i = 32'd7;
    pat_colour = 16'h0000;
    case (mode_q)
      2'd1:    pat_colour = bar_colour(3'(bar_i));
      2'd2:    pat_colour = (|(((32'(act_x) >> 5) ^ (32'(act_y) >> 5)) & 32'd1))
                            ? 16'hFFFF : 16'h0000;
      default: pat_colour = 16'h0000;
    endcase
    rgb_d = '0;
    if (de_d) rgb_d = (mode_q == 2'd0) ? pixel_data : DATA_W'(pat_colour);
  end

  // Outputs are registered from the current counters, so they lag them by one
  // cycle; the pixel_data sampled here answers the request issued REQ_LEAD
  // cycles earlier for the same position.
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !running) begin
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      data_req    <= req_d;
      pixel_xpos  <= req_d ? (cnt_h - RQ_S) : '0;
      pixel_ypos  <= req_d ? act_y : '0;
      vga_hs      <= (cnt_h < HS_END) ? HS_POL : ~HS_POL;
      vga_vs      <= (cnt_v < VS_END) ? VS_POL : ~VS_POL;
      vga_de      <= de_d;
      vga_rgb     <= rgb_d;
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
      line_start  <= (cnt_h == '0);
    end
  end

endmodule
